// File: rtl/digit_serial_adder.sv
// rtl/digit_serial_adder.sv - digit-serial adder, DIGIT bits per clock, valid/ready on both sides
// Optional subtract mode: define DSA_SUBTRACT_EN to add the sub port.
module digit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] augend,
    input  logic [WIDTH-1:0] addend,
    input  logic             carry_in,
`ifdef DSA_SUBTRACT_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_DIGIT = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q, ovf_q;

    logic             accept, last;
    logic [WIDTH-1:0] addend_eff;
    logic             cin_eff;
    logic [DIGIT:0]   dsum;
    logic             msb_cin;
    logic [WIDTH+DIGIT-1:0] res_cat, a_cat, b_cat;
    logic [WIDTH-1:0] res_next, a_next, b_next;

    // Subtraction folds into addition: a + ~b with the carry seeded by !carry_in.
`ifdef DSA_SUBTRACT_EN
    assign addend_eff = sub ? ~addend : addend;
    assign cin_eff    = sub ? ~carry_in : carry_in;
`else
    assign addend_eff = addend;
    assign cin_eff    = carry_in;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        last      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == LAST_DIGIT) begin
                    last    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Concatenate-and-slice keeps the shifts legal even when DIGIT == WIDTH.
    always_comb begin
        dsum     = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
        msb_cin  = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dsum[DIGIT-1];
        res_cat  = {dsum[DIGIT-1:0], res_q};
        a_cat    = {{DIGIT{1'b0}}, a_q};
        b_cat    = {{DIGIT{1'b0}}, b_q};
        res_next = res_cat[WIDTH+DIGIT-1:DIGIT];
        a_next   = a_cat[WIDTH+DIGIT-1:DIGIT];
        b_next   = b_cat[WIDTH+DIGIT-1:DIGIT];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_q     <= augend;
            b_q     <= addend_eff;
            carry_q <= cin_eff;
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            a_q     <= a_next;
            b_q     <= b_next;
            res_q   <= res_next;
            carry_q <= dsum[DIGIT];
            cnt_q   <= cnt_q + CW'(1);
            // Visible results change only when an operation completes.
            if (last) begin
                sum_q  <= res_next;
                cout_q <= dsum[DIGIT];
                ovf_q  <= msb_cin ^ dsum[DIGIT];
            end
        end
    end

    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;

endmodule
